// File: rtl/program_loader.sv
// Program loader: receives a byte stream (4-byte little-endian word-count header followed by
// the program image, little-endian 32-bit words) and writes it into instruction memory while
// holding the processor core in reset.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             request a load session (honoured in IDLE and ERR only)
//   byte_valid/_data  incoming byte stream
//   byte_ready        loader accepts a byte this cycle (HDR and DATA only)
//   im_we/_addr/_wd   instruction-memory write port (byte address, word aligned)
//   core_rst          hold-in-reset for the core, released after a successful load
//   busy, done, err   session in progress / one-cycle success pulse / sticky bad header
module program_loader #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wd,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StWrite,
    StDone,
    StErr
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q;
  logic [23:0] asm_q;       // first three bytes of the header/word being assembled
  logic [31:0] len_q;
  logic [31:0] word_idx_q;
  logic [31:0] im_addr_q;
  logic [31:0] im_wd_q;
  logic        core_rst_q;

  logic        accept;
  logic        last_byte;
  logic [31:0] full_word;
  logic        len_bad;
  logic        enter_hdr;

  assign accept    = byte_valid & byte_ready;
  assign last_byte = accept && (byte_cnt_q == 2'd3);
  assign full_word = {byte_data, asm_q};
  assign len_bad   = (full_word == 32'd0) || (full_word > 32'(DEPTH));
  assign enter_hdr = (state_d == StHdr) && (state_q != StHdr);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StHdr;
      StHdr:   if (last_byte) state_d = len_bad ? StErr : StData;
      StData:  if (last_byte) state_d = StWrite;
      StWrite: state_d = (word_idx_q == len_q - 32'd1) ? StDone : StData;
      StDone:  state_d = StIdle;
      StErr:   if (start) state_d = StHdr;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    byte_ready = 1'b0;
    im_we      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    unique case (state_q)
      StIdle:  ;
      StHdr:   begin byte_ready = 1'b1; busy = 1'b1; end
      StData:  begin byte_ready = 1'b1; busy = 1'b1; end
      StWrite: begin im_we = 1'b1; busy = 1'b1; end
      StDone:  begin done = 1'b1; busy = 1'b1; end
      StErr:   err = 1'b1;
      default: ;
    endcase
  end

  assign im_addr  = im_addr_q;
  assign im_wd    = im_wd_q;
  assign core_rst = core_rst_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= 2'd0;
      asm_q      <= 24'd0;
      len_q      <= 32'd0;
      word_idx_q <= 32'd0;
      im_addr_q  <= 32'd0;
      im_wd_q    <= 32'd0;
      core_rst_q <= 1'b1;
    end else begin
      if (enter_hdr) begin
        byte_cnt_q <= 2'd0;
        asm_q      <= 24'd0;
        len_q      <= 32'd0;
        word_idx_q <= 32'd0;
        core_rst_q <= 1'b1;
      end else begin
        if (accept) begin
          byte_cnt_q <= byte_cnt_q + 2'd1;
          // Shift right so the first byte ends up in bits 7:0 after four bytes.
          asm_q      <= {byte_data, asm_q[23:8]};
        end
        if (last_byte && state_q == StHdr) begin
          len_q <= full_word;
        end
        // Capture the write port at the last byte so WRITE follows one cycle later.
        if (last_byte && state_q == StData) begin
          im_addr_q <= word_idx_q << 2;
          im_wd_q   <= full_word;
        end
        if (state_q == StWrite) begin
          word_idx_q <= word_idx_q + 32'd1;
        end
        if (state_q == StDone) begin
          core_rst_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int unsigned DEPTH = 256;

  logic        clk;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wd;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        err;

  program_loader #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wd      (im_wd),
    .core_rst   (core_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Observed-side log, written only by the monitor.
  logic [63:0] wr_log[$];
  int          done_cnt = 0;
  int          rdy_in_write = 0;

  always @(negedge clk) begin
    if (im_we) begin
      wr_log.push_back({im_addr, im_wd});
      if (byte_ready) rdy_in_write++;
    end
    if (done) done_cnt++;
  end

  // Expected writes, pushed as stimulus is driven.
  logic [63:0] exp_q[$];
  int          word_idx;

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    int tries;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    tries = 0;
    while (!byte_ready && tries < 10) begin
      @(posedge clk);
      #1;
      tries++;
    end
    n_cmp++;
    if (!byte_ready) begin
      n_bad++;
      $display("FAIL byte_accept: byte_ready=%0b required 1 within 10 cycles", byte_ready);
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] len);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], 0);
    word_idx = 0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    exp_q.push_back({32'(word_idx * 4), w});
    word_idx++;
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], max_gap);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (busy) begin
      n_bad++;
      $display("FAIL %s_idle: busy=%0b required 0 within 20 cycles", name, busy);
    end
  endtask

  task automatic check_writes(input string name, input int base);
    logic [63:0] e;
    n_cmp++;
    if (wr_log.size() - base != exp_q.size()) begin
      n_bad++;
      $display("FAIL %s_count: writes=%0d required %0d", name, wr_log.size() - base,
               exp_q.size());
    end
    for (int i = 0; i < wr_log.size() - base && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (wr_log[base+i] !== e) begin
        n_bad++;
        $display("FAIL %s_write%0d: addr/data=%h/%h required %h/%h", name, i,
                 wr_log[base+i][63:32], wr_log[base+i][31:0], e[63:32], e[31:0]);
      end
    end
    exp_q.delete();
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0b required %0b", name, act, req);
    end
  endtask

  task automatic check_reset_values(input string name);
    n_cmp++;
    if ({byte_ready, im_we, core_rst, busy, done, err} !== 6'b001000 ||
        im_addr !== 32'd0 || im_wd !== 32'd0) begin
      n_bad++;
      $display("FAIL %s: rdy/we/crst/busy/done/err=%b addr=%h wd=%h required 001000 0 0",
               name, {byte_ready, im_we, core_rst, busy, done, err}, im_addr, im_wd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    check_reset_values("reset_state");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("after_release");
  endtask

  task automatic test_basic();
    int base, d0;
    base = wr_log.size();
    d0   = done_cnt;
    do_start();
    check_bit("basic_core_held", core_rst, 1'b1);
    send_hdr(32'd2);
    send_word(32'h0050_0513, 0);
    send_word(32'h0060_0593, 0);
    wait_idle("basic");
    check_writes("basic", base);
    n_cmp++;
    if (done_cnt - d0 != 1) begin
      n_bad++;
      $display("FAIL basic_done: pulses=%0d required 1", done_cnt - d0);
    end
    check_bit("basic_core_rst", core_rst, 1'b0);
  endtask

  task automatic test_zero_len();
    int base, d0;
    base = wr_log.size();
    do_start();
    send_hdr(32'd0);
    repeat (3) @(posedge clk);
    #1;
    check_bit("zero_err", err, 1'b1);
    check_bit("zero_core_rst", core_rst, 1'b1);
    check_bit("zero_busy", busy, 1'b0);
    check_writes("zero", base);
    base = wr_log.size();
    d0   = done_cnt;
    do_start();
    check_bit("zero_err_cleared", err, 1'b0);
    send_hdr(32'd1);
    send_word(32'hDEAD_BEEF, 0);
    wait_idle("zero_reload");
    check_writes("zero_reload", base);
    check_bit("zero_reload_done", (done_cnt - d0) == 1, 1'b1);
    check_bit("zero_reload_core_rst", core_rst, 1'b0);
  endtask

  task automatic test_len_limits();
    int base;
    base = wr_log.size();
    do_start();
    send_hdr(DEPTH + 1);
    repeat (3) @(posedge clk);
    #1;
    check_bit("over_err", err, 1'b1);
    check_writes("over", base);
    base = wr_log.size();
    do_start();
    send_hdr(DEPTH);
    for (int i = 0; i < DEPTH; i++) send_word($urandom, 0);
    wait_idle("full");
    n_cmp++;
    if (wr_log.size() == 0 || wr_log[wr_log.size()-1][63:32] !== 32'h0000_03FC) begin
      n_bad++;
      $display("FAIL full_last_addr: got %h required 000003fc",
               (wr_log.size() == 0) ? 32'hx : wr_log[wr_log.size()-1][63:32]);
    end
    check_writes("full", base);
  endtask

  task automatic test_gaps();
    int base, r0;
    base = wr_log.size();
    r0   = rdy_in_write;
    do_start();
    send_hdr(32'd3);
    send_word(32'h0050_0513, 3);
    send_word(32'h0060_0593, 3);
    send_word(32'h00B5_0633, 3);
    wait_idle("gaps");
    check_writes("gaps", base);
    n_cmp++;
    if (rdy_in_write != r0) begin
      n_bad++;
      $display("FAIL gaps_ready_in_write: count=%0d required 0", rdy_in_write - r0);
    end
  endtask

  task automatic test_async_reset();
    int base;
    base = wr_log.size();
    do_start();
    send_hdr(32'd2);
    send_word(32'h1234_5678, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #3;
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_writes("async_partial", base);
    check_bit("async_core_held", core_rst, 1'b1);
    check_bit("async_idle", busy, 1'b0);
    base = wr_log.size();
    do_start();
    send_hdr(32'd1);
    send_word(32'hCAFE_F00D, 0);
    wait_idle("async_reload");
    check_writes("async_reload", base);
    check_bit("async_reload_core_rst", core_rst, 1'b0);
  endtask

  task automatic test_start_while_busy();
    int base, d0;
    base = wr_log.size();
    d0   = done_cnt;
    do_start();
    send_hdr(32'd2);
    send_byte(8'h11, 0);
    do_start();
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    start = 1'b1;
    send_byte(8'h44, 0);
    start = 1'b0;
    exp_q.push_back({32'd0, 32'h4433_2211});
    word_idx = 1;
    send_word(32'h0102_0304, 0);
    wait_idle("busy_start");
    check_writes("busy_start", base);
    check_bit("busy_start_done", (done_cnt - d0) == 1, 1'b1);
    check_bit("busy_start_core_rst", core_rst, 1'b0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    word_idx   = 0;
    test_reset();
    test_basic();
    test_zero_len();
    test_len_limits();
    test_gaps();
    test_async_reset();
    test_start_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
